// File: rtl/iq_pkg.sv
// Shared issue-entry layout and queue sizing for the issue queue and the
// functional units that consume its entries.
package iq_pkg;

   localparam int IQ_DEPTH = 8;
   localparam int ENTRY_W  = 139;
   localparam int TAG_W    = 6;
   localparam int VAL_W    = 32;

   localparam int FUNCT3_MSB   = 138;
   localparam int FUNCT3_LSB   = 136;
   localparam int FUNCT7_MSB   = 135;
   localparam int FUNCT7_LSB   = 129;
   localparam int OPCODE_MSB   = 128;
   localparam int OPCODE_LSB   = 122;
   localparam int PHYS_RD_MSB  = 121;
   localparam int PHYS_RD_LSB  = 116;
   localparam int PHYS_RS1_MSB = 115;
   localparam int PHYS_RS1_LSB = 110;
   localparam int RS1_VAL_MSB  = 109;
   localparam int RS1_VAL_LSB  = 78;
   localparam int PHYS_RS2_MSB = 77;
   localparam int PHYS_RS2_LSB = 72;
   localparam int RS2_VAL_MSB  = 71;
   localparam int RS2_VAL_LSB  = 40;
   localparam int IMM_MSB      = 39;
   localparam int IMM_LSB      = 8;
   localparam int ROB_IDX_MSB  = 7;
   localparam int ROB_IDX_LSB  = 2;
   localparam int FU_CNT_MSB   = 1;
   localparam int FU_CNT_LSB   = 0;

endpackage

// File: rtl/iq_select.sv
// Lowest-index priority picker: grants the first set request bit.
module iq_select #(
   parameter int N = 8
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic         found
);

   // Scan upward so the oldest eligible slot wins
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && !found) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/issue_queue.sv
// Collapsing issue queue: oldest entry in slot 0, operand wakeup by tag
// broadcast, one dispatch and one registered issue per cycle.
module issue_queue #(
   parameter int IQ_DEPTH = iq_pkg::IQ_DEPTH,
   parameter int ENTRY_W  = iq_pkg::ENTRY_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          dispatch_valid,
   input  logic [ENTRY_W-1:0]            dispatch_entry,
   input  logic                          dispatch_rs1_rdy,
   input  logic                          dispatch_rs2_rdy,
   output logic                          dispatch_ready,
   input  logic                          wakeup_valid,
   input  logic [5:0]                    wakeup_tag,
   input  logic [31:0]                   wakeup_value,
   input  logic                          fu_ready,
   input  logic                          flush,
   output logic [ENTRY_W-1:0]            issue_entry,
   output logic                          issue_enable,
   output logic [$clog2(IQ_DEPTH):0]     count
);
   import iq_pkg::*;

   localparam int CW = $clog2(IQ_DEPTH) + 1;

   logic [ENTRY_W-1:0]  slot_q [IQ_DEPTH];
   logic [IQ_DEPTH-1:0] valid_q, rs1_rdy_q, rs2_rdy_q;
   logic [CW-1:0]       count_q;
   logic [ENTRY_W-1:0]  issue_entry_q;
   logic                issue_enable_q;

   logic [ENTRY_W-1:0]  slot_w [IQ_DEPTH];
   logic [IQ_DEPTH-1:0] rs1_w, rs2_w;
   logic [ENTRY_W-1:0]  disp_w;
   logic                disp_rs1_w, disp_rs2_w;

   logic [ENTRY_W-1:0]  slot_n [IQ_DEPTH];
   logic [IQ_DEPTH-1:0] valid_n, rs1_n, rs2_n;

   logic [IQ_DEPTH-1:0] ready_vec, grant, shift_mask;
   logic                found;
   logic [ENTRY_W-1:0]  sel_entry;
   logic                do_issue, do_dispatch, wake_ok;
   logic [CW-1:0]       write_idx, count_n;

   assign dispatch_ready = (count_q != CW'(IQ_DEPTH));
   assign wake_ok        = wakeup_valid && (wakeup_tag != 6'd0);
   assign ready_vec      = valid_q & rs1_rdy_q & rs2_rdy_q;
   assign do_issue       = found && fu_ready && !flush;
   assign do_dispatch    = dispatch_valid && dispatch_ready && !flush;
   assign write_idx      = count_q - CW'(do_issue);
   assign count_n        = count_q + CW'(do_dispatch) - CW'(do_issue);

   assign issue_entry  = issue_entry_q;
   assign issue_enable = issue_enable_q;
   assign count        = count_q;

   iq_select #(.N(IQ_DEPTH)) u_select (
      .req   (ready_vec),
      .grant (grant),
      .found (found)
   );

   // Apply the result broadcast to waiting operands of queued and incoming entries
   always_comb begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
         slot_w[i] = slot_q[i];
         rs1_w[i]  = rs1_rdy_q[i];
         rs2_w[i]  = rs2_rdy_q[i];
         if (wake_ok && valid_q[i] && !rs1_rdy_q[i] &&
             slot_q[i][PHYS_RS1_MSB:PHYS_RS1_LSB] == wakeup_tag) begin
            slot_w[i][RS1_VAL_MSB:RS1_VAL_LSB] = wakeup_value;
            rs1_w[i] = 1'b1;
         end
         if (wake_ok && valid_q[i] && !rs2_rdy_q[i] &&
             slot_q[i][PHYS_RS2_MSB:PHYS_RS2_LSB] == wakeup_tag) begin
            slot_w[i][RS2_VAL_MSB:RS2_VAL_LSB] = wakeup_value;
            rs2_w[i] = 1'b1;
         end
      end
      disp_w     = dispatch_entry;
      disp_rs1_w = dispatch_rs1_rdy;
      disp_rs2_w = dispatch_rs2_rdy;
      if (wake_ok && !dispatch_rs1_rdy &&
          dispatch_entry[PHYS_RS1_MSB:PHYS_RS1_LSB] == wakeup_tag) begin
         disp_w[RS1_VAL_MSB:RS1_VAL_LSB] = wakeup_value;
         disp_rs1_w = 1'b1;
      end
      if (wake_ok && !dispatch_rs2_rdy &&
          dispatch_entry[PHYS_RS2_MSB:PHYS_RS2_LSB] == wakeup_tag) begin
         disp_w[RS2_VAL_MSB:RS2_VAL_LSB] = wakeup_value;
         disp_rs2_w = 1'b1;
      end
   end

   // Pick the granted entry and mark every slot at or above it for collapse
   always_comb begin
      logic acc;
      acc       = 1'b0;
      sel_entry = '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
         if (grant[i]) begin
            sel_entry = sel_entry | slot_q[i];
         end
         acc           = acc | grant[i];
         shift_mask[i] = acc;
      end
   end

   // Build next slot contents: collapse over the issued slot, then append the dispatch
   always_comb begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
         slot_n[i]  = slot_w[i];
         valid_n[i] = valid_q[i];
         rs1_n[i]   = rs1_w[i];
         rs2_n[i]   = rs2_w[i];
      end
      if (do_issue) begin
         for (int i = 0; i < IQ_DEPTH - 1; i++) begin
            if (shift_mask[i]) begin
               slot_n[i]  = slot_w[i+1];
               valid_n[i] = valid_q[i+1];
               rs1_n[i]   = rs1_w[i+1];
               rs2_n[i]   = rs2_w[i+1];
            end
         end
         valid_n[IQ_DEPTH-1] = 1'b0;
         rs1_n[IQ_DEPTH-1]   = 1'b0;
         rs2_n[IQ_DEPTH-1]   = 1'b0;
      end
      if (do_dispatch) begin
         for (int i = 0; i < IQ_DEPTH; i++) begin
            if (write_idx == CW'(i)) begin
               slot_n[i]  = disp_w;
               valid_n[i] = 1'b1;
               rs1_n[i]   = disp_rs1_w;
               rs2_n[i]   = disp_rs2_w;
            end
         end
      end
   end

   // Payload storage needs no reset; slot validity is tracked separately
   always_ff @(posedge clk) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
         slot_q[i] <= slot_n[i];
      end
   end

   // Control state and issue register; reset beats flush, flush beats everything else
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_q        <= '0;
         rs1_rdy_q      <= '0;
         rs2_rdy_q      <= '0;
         count_q        <= '0;
         issue_enable_q <= 1'b0;
         issue_entry_q  <= '0;
      end else begin
         valid_q        <= valid_n;
         rs1_rdy_q      <= rs1_n;
         rs2_rdy_q      <= rs2_n;
         count_q        <= count_n;
         issue_enable_q <= do_issue;
         issue_entry_q  <= do_issue ? sel_entry : '0;
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: a vector table for the single-entry flows
// plus hand sequences for fill/drain, flush and mid-run reset.
module tb_issue_queue;

   localparam logic [6:0] OP_ADD = 7'b0110011;

   logic         clk;
   logic         rst;
   logic         dispatch_valid;
   logic [138:0] dispatch_entry;
   logic         dispatch_rs1_rdy;
   logic         dispatch_rs2_rdy;
   logic         dispatch_ready;
   logic         wakeup_valid;
   logic [5:0]   wakeup_tag;
   logic [31:0]  wakeup_value;
   logic         fu_ready;
   logic         flush;
   logic [138:0] issue_entry;
   logic         issue_enable;
   logic [3:0]   count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string        name;
      logic         rst;
      logic         dv;
      logic [138:0] de;
      logic         r1;
      logic         r2;
      logic         wv;
      logic [5:0]   wt;
      logic [31:0]  wval;
      logic         fu;
      logic         fl;
      logic         exp_ie;
      logic [138:0] exp_entry;
      logic [3:0]   exp_cnt;
      logic         exp_dr;
   } vec_t;

   issue_queue dut (
      .clk              (clk),
      .rst              (rst),
      .dispatch_valid   (dispatch_valid),
      .dispatch_entry   (dispatch_entry),
      .dispatch_rs1_rdy (dispatch_rs1_rdy),
      .dispatch_rs2_rdy (dispatch_rs2_rdy),
      .dispatch_ready   (dispatch_ready),
      .wakeup_valid     (wakeup_valid),
      .wakeup_tag       (wakeup_tag),
      .wakeup_value     (wakeup_value),
      .fu_ready         (fu_ready),
      .flush            (flush),
      .issue_entry      (issue_entry),
      .issue_enable     (issue_enable),
      .count            (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [138:0] mk(input logic [5:0] rd, input logic [5:0] rs1,
                                       input logic [31:0] v1, input logic [5:0] rs2,
                                       input logic [31:0] v2, input logic [5:0] rob);
      return {3'b000, 7'b0000000, OP_ADD, rd, rs1, v1, rs2, v2, 32'h0000_0100, rob, 2'b01};
   endfunction

   function automatic vec_t mkv(input string n, input logic r, input logic dv,
                                input logic [138:0] de, input logic r1, input logic r2,
                                input logic wv, input logic [5:0] wt, input logic [31:0] wval,
                                input logic fu, input logic fl, input logic eie,
                                input logic [138:0] ee, input logic [3:0] ec, input logic edr);
      vec_t v;
      v.name = n; v.rst = r; v.dv = dv; v.de = de; v.r1 = r1; v.r2 = r2;
      v.wv = wv; v.wt = wt; v.wval = wval; v.fu = fu; v.fl = fl;
      v.exp_ie = eie; v.exp_entry = ee; v.exp_cnt = ec; v.exp_dr = edr;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst              = v.rst;
      dispatch_valid   = v.dv;
      dispatch_entry   = v.de;
      dispatch_rs1_rdy = v.r1;
      dispatch_rs2_rdy = v.r2;
      wakeup_valid     = v.wv;
      wakeup_tag       = v.wt;
      wakeup_value     = v.wval;
      fu_ready         = v.fu;
      flush            = v.fl;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string n, input logic eie, input logic [138:0] ee,
                              input logic [3:0] ec, input logic edr);
      checks++;
      if (issue_enable !== eie) begin
         errors++;
         $display("[TB] FAIL %s issue_enable got %b expected %b", n, issue_enable, eie);
      end
      checks++;
      if (issue_entry !== ee) begin
         errors++;
         $display("[TB] FAIL %s issue_entry got %h expected %h", n, issue_entry, ee);
      end
      checks++;
      if (count !== ec) begin
         errors++;
         $display("[TB] FAIL %s count got %0d expected %0d", n, count, ec);
      end
      checks++;
      if (dispatch_ready !== edr) begin
         errors++;
         $display("[TB] FAIL %s dispatch_ready got %b expected %b", n, dispatch_ready, edr);
      end
   endtask

   initial begin
      vec_t         vecs[18];
      vec_t         v;
      logic [138:0] e_add, e_b, e_b_w, e_c, e_c_w, e_d, e_d_w, e_e, e_f, e_x;
      logic [138:0] fill[8];

      e_add = mk(6'd3, 6'd1, 32'h11, 6'd2, 32'h22, 6'd5);
      e_b   = mk(6'd4, 6'd12, 32'h0, 6'd2, 32'h33, 6'd6);
      e_b_w = mk(6'd4, 6'd12, 32'hDEADBEEF, 6'd2, 32'h33, 6'd6);
      e_c   = mk(6'd5, 6'd7, 32'h77, 6'd9, 32'h0, 6'd7);
      e_c_w = mk(6'd5, 6'd7, 32'h77, 6'd9, 32'hCAFEF00D, 6'd7);
      e_d   = mk(6'd6, 6'd20, 32'h0, 6'd8, 32'h88, 6'd8);
      e_d_w = mk(6'd6, 6'd20, 32'h55, 6'd8, 32'h88, 6'd8);
      e_e   = mk(6'd7, 6'd1, 32'h1, 6'd2, 32'h2, 6'd9);
      e_f   = mk(6'd8, 6'd3, 32'h3, 6'd4, 32'h4, 6'd10);
      e_x   = mk(6'd9, 6'd5, 32'h5, 6'd6, 32'h6, 6'd30);

      //               name           rst dv de    r1 r2 wv wt     wval           fu fl   ie entry  cnt dr
      vecs[0]  = mkv("reset",        1, 0, '0,    0, 0, 0, 6'd0,  32'h0,         1, 0,   0, '0,    0, 1);
      vecs[1]  = mkv("disp_add",     0, 1, e_add, 1, 1, 0, 6'd0,  32'h0,         1, 0,   0, '0,    1, 1);
      vecs[2]  = mkv("add_issue",    0, 0, '0,    0, 0, 0, 6'd0,  32'h0,         1, 0,   1, e_add, 0, 1);
      vecs[3]  = mkv("add_idle",     0, 0, '0,    0, 0, 0, 6'd0,  32'h0,         1, 0,   0, '0,    0, 1);
      vecs[4]  = mkv("disp_b",       0, 1, e_b,   0, 1, 0, 6'd0,  32'h0,         1, 0,   0, '0,    1, 1);
      vecs[5]  = mkv("b_wait",       0, 0, '0,    0, 0, 0, 6'd0,  32'h0,         1, 0,   0, '0,    1, 1);
      vecs[6]  = mkv("b_wrong_tag",  0, 0, '0,    0, 0, 1, 6'd13, 32'h1234,      1, 0,   0, '0,    1, 1);
      vecs[7]  = mkv("b_wakeup",     0, 0, '0,    0, 0, 1, 6'd12, 32'hDEADBEEF,  1, 0,   0, '0,    1, 1);
      vecs[8]  = mkv("b_issue",      0, 0, '0,    0, 0, 0, 6'd0,  32'h0,         1, 0,   1, e_b_w, 0, 1);
      vecs[9]  = mkv("c_bypass",     0, 1, e_c,   1, 0, 1, 6'd9,  32'hCAFEF00D,  1, 0,   0, '0,    1, 1);
      vecs[10] = mkv("c_issue",      0, 0, '0,    0, 0, 0, 6'd0,  32'h0,         1, 0,   1, e_c_w, 0, 1);
      vecs[11] = mkv("c_idle",       0, 0, '0,    0, 0, 0, 6'd0,  32'h0,         1, 0,   0, '0,    0, 1);
      vecs[12] = mkv("disp_d",       0, 1, e_d,   0, 1, 0, 6'd0,  32'h0,         0, 0,   0, '0,    1, 1);
      vecs[13] = mkv("disp_e",       0, 1, e_e,   1, 1, 0, 6'd0,  32'h0,         0, 0,   0, '0,    2, 1);
      vecs[14] = mkv("e_iss_f_disp", 0, 1, e_f,   1, 1, 0, 6'd0,  32'h0,         1, 0,   1, e_e,   2, 1);
      vecs[15] = mkv("f_iss_d_wake", 0, 0, '0,    0, 0, 1, 6'd20, 32'h55,        1, 0,   1, e_f,   1, 1);
      vecs[16] = mkv("d_issue",      0, 0, '0,    0, 0, 0, 6'd0,  32'h0,         1, 0,   1, e_d_w, 0, 1);
      vecs[17] = mkv("d_idle",       0, 0, '0,    0, 0, 0, 6'd0,  32'h0,         1, 0,   0, '0,    0, 1);

      for (int k = 0; k < 18; k++) begin
         applyStimulus(vecs[k]);
         checkOutput(vecs[k].name, vecs[k].exp_ie, vecs[k].exp_entry,
                     vecs[k].exp_cnt, vecs[k].exp_dr);
      end

      // Fill to capacity with the FU stalled, try an overflow, then drain in order
      for (int i = 0; i < 8; i++) begin
         fill[i] = mk(6'(i + 10), 6'd1, 32'(i * 16 + 1), 6'd2, 32'(i * 16 + 2), 6'(i + 1));
         v = mkv("fill", 0, 1, fill[i], 1, 1, 0, 6'd0, 32'h0, 0, 0, 0, '0, 0, 0);
         applyStimulus(v);
         checkOutput("fill", 1'b0, '0, 4'(i + 1), (i < 7));
      end
      v = mkv("overflow", 0, 1, e_x, 1, 1, 0, 6'd0, 32'h0, 0, 0, 0, '0, 0, 0);
      applyStimulus(v);
      checkOutput("full_ignore", 1'b0, '0, 4'd8, 1'b0);
      for (int i = 0; i < 8; i++) begin
         v = mkv("drain", 0, 0, '0, 0, 0, 0, 6'd0, 32'h0, 1, 0, 0, '0, 0, 0);
         applyStimulus(v);
         checkOutput("drain", 1'b1, fill[i], 4'(7 - i), 1'b1);
      end
      v = mkv("drain_end", 0, 0, '0, 0, 0, 0, 6'd0, 32'h0, 1, 0, 0, '0, 0, 0);
      applyStimulus(v);
      checkOutput("drain_end", 1'b0, '0, 4'd0, 1'b1);

      // Five queued entries, flush alongside a dispatch and a willing FU
      for (int i = 0; i < 5; i++) begin
         v = mkv("pre_flush", 0, 1, fill[i], 1, 1, 0, 6'd0, 32'h0, 0, 0, 0, '0, 0, 0);
         applyStimulus(v);
         checkOutput("pre_flush", 1'b0, '0, 4'(i + 1), 1'b1);
      end
      v = mkv("flush", 0, 1, e_x, 1, 1, 0, 6'd0, 32'h0, 1, 1, 0, '0, 0, 0);
      applyStimulus(v);
      checkOutput("flush", 1'b0, '0, 4'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         v = mkv("post_flush", 0, 0, '0, 0, 0, 0, 6'd0, 32'h0, 1, 0, 0, '0, 0, 0);
         applyStimulus(v);
         checkOutput("post_flush", 1'b0, '0, 4'd0, 1'b1);
      end

      // Reset in the middle of operation drops queued work without issuing
      for (int i = 0; i < 2; i++) begin
         v = mkv("pre_rst", 0, 1, fill[i], 1, 1, 0, 6'd0, 32'h0, 0, 0, 0, '0, 0, 0);
         applyStimulus(v);
         checkOutput("pre_rst", 1'b0, '0, 4'(i + 1), 1'b1);
      end
      v = mkv("mid_rst", 1, 1, e_x, 1, 1, 1, 6'd1, 32'h9, 1, 1, 0, '0, 0, 0);
      applyStimulus(v);
      checkOutput("mid_rst", 1'b0, '0, 4'd0, 1'b1);
      v = mkv("post_rst", 0, 0, '0, 0, 0, 0, 6'd0, 32'h0, 1, 0, 0, '0, 0, 0);
      applyStimulus(v);
      checkOutput("post_rst", 1'b0, '0, 4'd0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
